// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 key-event path.
//   - Set-2 prefix and modifier byte constants, plus the list of bytes the
//     keyboard sends that are not key data (ACK, BAT, echo, errors).
//   - Decoder FSM state enum.
//   - Packed event word as stored in the event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_LSHIFT     = 8'h12;
  localparam logic [7:0] PS2_RSHIFT     = 8'h59;
  localparam logic [7:0] PS2_CTRL       = 8'h14;
  localparam logic [7:0] PS2_ALT        = 8'h11;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

  // Bytes following E1 that belong to the pause sequence (E1 itself excluded).
  localparam logic [2:0] PS2_PAUSE_LEN  = 3'd7;

  localparam int PS2_NUM_DISCARD = 8;
  localparam logic [7:0] PS2_DISCARD [PS2_NUM_DISCARD] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
  };

  function automatic logic ps2_is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_DISCARD; i++) begin
      if (b == PS2_DISCARD[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  // mods = {alt, ctrl, rshift, lshift}
  typedef struct packed {
    logic [3:0] mods;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam int PS2_EVENT_W = $bits(ps2_event_t);

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous show-ahead FIFO with occupancy count.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, wdata : write request and data (ignored when full unless popping)
//   pop         : read request (ignored when empty)
//   rdata       : head entry, driven straight from storage
//   full, empty : status flags
//   count       : entries currently held (0..DEPTH)
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// ps2_key_event: folds raw PS/2 set-2 scan bytes into key events.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid, in_data : one-cycle strobe with a raw scan byte
//   ev_valid/ev_ready : head-of-queue handshake toward the consumer
//   ev_code, ev_ext, ev_break, ev_mods : head event fields
//   ev_count          : events queued
//   overflow, ovf_clr : sticky drop flag and its clear
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [3:0]                    ev_mods,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  ps2_state_e state_q, state_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic       lalt_q, lalt_d, ralt_q, ralt_d;
  logic       last_vld_q, last_vld_d;
  logic       last_ext_q, last_ext_d;
  logic [7:0] last_code_q, last_code_d;
  logic       overflow_q, overflow_d;

  logic       emit, emit_ext, emit_brk, is_pause_ev;
  logic [7:0] emit_code;
  logic       is_disc, is_repeat, push_req, push_ok;
  logic       fifo_full, fifo_empty;
  ps2_event_t new_ev, head_ev;

  assign is_disc = ps2_is_discard(in_data);

  // Prefix decoder: only bytes strobed by in_valid move the state.
  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    emit        = 1'b0;
    emit_ext    = 1'b0;
    emit_brk    = 1'b0;
    emit_code   = in_data;
    is_pause_ev = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data == PS2_EXT)        state_d = ST_EXT;
          else if (in_data == PS2_BRK)   state_d = ST_BRK;
          else if (in_data == PS2_PAUSE) begin
            state_d = ST_PAUSE;
            pcnt_d  = PS2_PAUSE_LEN;
          end else if (!is_disc)         emit = 1'b1;
        end
        ST_EXT: begin
          if (in_data == PS2_EXT)        state_d = ST_EXT;
          else if (in_data == PS2_BRK)   state_d = ST_EXT_BRK;
          else if (in_data == PS2_PAUSE) begin
            state_d = ST_PAUSE;
            pcnt_d  = PS2_PAUSE_LEN;
          end else if (is_disc)          state_d = ST_IDLE;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (in_data == PS2_BRK)        state_d = ST_BRK;
          else if (in_data == PS2_PAUSE) begin
            state_d = ST_PAUSE;
            pcnt_d  = PS2_PAUSE_LEN;
          end else if (is_disc)          state_d = ST_IDLE;
          else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (in_data == PS2_PAUSE) begin
            state_d = ST_PAUSE;
            pcnt_d  = PS2_PAUSE_LEN;
          end else if (is_disc)          state_d = ST_IDLE;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          // The pause sequence content is fixed, so bytes are only counted.
          if (pcnt_q == 3'd1) begin
            emit        = 1'b1;
            emit_ext    = 1'b1;
            emit_code   = PS2_PAUSE_CODE;
            is_pause_ev = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            pcnt_d = pcnt_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Modifier tracking; applies even if the event is later dropped.
  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    lalt_d   = lalt_q;
    ralt_d   = ralt_q;
    if (emit && !is_pause_ev) begin
      case (emit_code)
        PS2_LSHIFT: lshift_d = !emit_brk;
        PS2_RSHIFT: rshift_d = !emit_brk;
        PS2_CTRL: begin
          if (emit_ext) rctrl_d = !emit_brk;
          else          lctrl_d = !emit_brk;
        end
        PS2_ALT: begin
          if (emit_ext) ralt_d = !emit_brk;
          else          lalt_d = !emit_brk;
        end
        default: ;
      endcase
    end
  end

  assign new_ev.mods = {lalt_d | ralt_d, lctrl_d | rctrl_d, rshift_d, lshift_d};
  assign new_ev.ext  = emit_ext;
  assign new_ev.brk  = emit_brk;
  assign new_ev.code = emit_code;

  assign is_repeat = (SUPPRESS_REPEAT != 0) && emit && !emit_brk && !is_pause_ev &&
                     last_vld_q && (last_ext_q == emit_ext) && (last_code_q == emit_code);
  assign push_req  = emit && !is_repeat;
  assign push_ok   = push_req && (!fifo_full || (ev_ready && !fifo_empty));

  // Only a make that actually entered the queue becomes the repeat reference,
  // so a make lost to overflow can be retried by the next typematic byte.
  always_comb begin
    last_vld_d  = last_vld_q;
    last_ext_d  = last_ext_q;
    last_code_d = last_code_q;
    if (emit && emit_brk) begin
      last_vld_d = 1'b0;
    end else if (push_ok && !is_pause_ev) begin
      last_vld_d  = 1'b1;
      last_ext_d  = emit_ext;
      last_code_d = emit_code;
    end
  end

  // A drop in the same cycle as the clear keeps the flag set.
  assign overflow_d = (push_req && !push_ok) || (overflow_q && !ovf_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      last_vld_q  <= 1'b0;
      last_ext_q  <= 1'b0;
      last_code_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      last_vld_q  <= last_vld_d;
      last_ext_q  <= last_ext_d;
      last_code_q <= last_code_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push_req),
    .wdata (new_ev),
    .pop   (ev_ready),
    .rdata (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ev_count)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign ev_break = head_ev.brk;
  assign ev_mods  = head_ev.mods;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_event.sv
module tb_ps2_key_event;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic       ev_valid, ev_ext, ev_break, overflow;
  logic [7:0] ev_code;
  logic [3:0] ev_mods;
  logic [3:0] ev_count;

  logic       ev_valid2, ev_ext2, ev_break2, overflow2;
  logic [7:0] ev_code2;
  logic [3:0] ev_mods2;
  logic [3:0] ev_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_key_event #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_mods(ev_mods), .ev_count(ev_count),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  ps2_key_event #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(0)) dut_norep (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .ev_valid(ev_valid2), .ev_ready(ev_ready), .ev_code(ev_code2), .ev_ext(ev_ext2),
    .ev_break(ev_break2), .ev_mods(ev_mods2), .ev_count(ev_count2),
    .overflow(overflow2), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [7:0] b;
    bit         has_ev;
    logic [7:0] code;
    bit         ext;
    bit         brk;
    logic [3:0] mods;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] b, input bit has_ev, input logic [7:0] code,
                     input bit ext, input bit brk, input logic [3:0] mods);
    vec_t v;
    v.b = b; v.has_ev = has_ev; v.code = code; v.ext = ext; v.brk = brk; v.mods = mods;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(posedge clk);
    #1;
    ev_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [31:0] word(input logic [7:0] code, input logic ext,
                                       input logic brk, input logic [3:0] mods);
    return {18'd0, code, ext, brk, mods};
  endfunction

  logic [7:0] ovf_codes [9];
  logic [7:0] drain_codes [8];

  initial begin
    // Byte stream, expected event after that byte (if any).
    add(8'h1C, 1, 8'h1C, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h1C, 1, 8'h1C, 0, 1, 4'b0000);
    add(8'h12, 1, 8'h12, 0, 0, 4'b0001);
    add(8'h1C, 1, 8'h1C, 0, 0, 4'b0001);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h12, 1, 8'h12, 0, 1, 4'b0000);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h75, 1, 8'h75, 1, 0, 4'b0000);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h75, 1, 8'h75, 1, 1, 4'b0000);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h14, 1, 8'h14, 1, 0, 4'b0100);
    add(8'hAA, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hFA, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hE1, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h14, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h77, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hE1, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h14, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h77, 1, 8'h77, 1, 0, 4'b0100);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h14, 1, 8'h14, 1, 1, 4'b0000);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hAA, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h1C, 1, 8'h1C, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hFF, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h1C, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h1C, 1, 8'h1C, 0, 1, 4'b0000);
    add(8'h11, 1, 8'h11, 0, 0, 4'b1000);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h11, 1, 8'h11, 1, 0, 4'b1000);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h11, 1, 8'h11, 1, 1, 4'b1000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h11, 1, 8'h11, 0, 1, 4'b0000);
    add(8'h59, 1, 8'h59, 0, 0, 4'b0010);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hF0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h59, 1, 8'h59, 0, 1, 4'b0000);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'hE0, 0, 8'h00, 0, 0, 4'b0000);
    add(8'h75, 1, 8'h75, 1, 0, 4'b0000);

    ovf_codes   = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    drain_codes = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    // Reset state, sampled while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("reset ev_valid", 32'(ev_valid), 32'd0);
    chk("reset ev_count", 32'(ev_count), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset head", word(ev_code, ev_ext, ev_break, ev_mods), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven byte stream.
    foreach (vecs[i]) begin
      send_byte(vecs[i].b);
      $display("vec %0d byte %02h ev_valid %0b head %02h ext %0b brk %0b mods %04b",
               i, vecs[i].b, ev_valid, ev_code, ev_ext, ev_break, ev_mods);
      chk($sformatf("vec%0d ev_valid", i), 32'(ev_valid), 32'(vecs[i].has_ev));
      if (vecs[i].has_ev) begin
        chk($sformatf("vec%0d event", i), word(ev_code, ev_ext, ev_break, ev_mods),
            word(vecs[i].code, vecs[i].ext, vecs[i].brk, vecs[i].mods));
        pop_one();
      end
    end

    // Typematic repeat: filtered vs unfiltered instance.
    pulse_reset();
    repeat (3) send_byte(8'h1C);
    $display("repeat: count %0d (filtered) %0d (unfiltered)", ev_count, ev_count2);
    chk("repeat filtered count", 32'(ev_count), 32'd1);
    chk("repeat unfiltered count", 32'(ev_count2), 32'd3);
    chk("repeat unfiltered valid", 32'(ev_valid2), 32'd1);
    chk("repeat unfiltered head", word(ev_code2, ev_ext2, ev_break2, ev_mods2),
        word(8'h1C, 1'b0, 1'b0, 4'b0000));
    chk("repeat unfiltered overflow", 32'(overflow2), 32'd0);
    repeat (3) pop_one();
    chk("repeat drained filtered", 32'(ev_count), 32'd0);
    chk("repeat drained unfiltered", 32'(ev_count2), 32'd0);

    // Overflow: 9 distinct makes into an 8-entry queue.
    pulse_reset();
    foreach (ovf_codes[i]) send_byte(ovf_codes[i]);
    $display("overflow fill: count %0d overflow %0b head %02h", ev_count, overflow, ev_code);
    chk("ovf count full", 32'(ev_count), 32'd8);
    chk("ovf flag", 32'(overflow), 32'd1);
    chk("ovf head", 32'(ev_code), 32'h15);

    // Lost make retried while a pop frees a slot in the same cycle.
    in_data = 8'h44; in_valid = 1'b1; ev_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; ev_ready = 1'b0;
    $display("push+pop on full: count %0d head %02h", ev_count, ev_code);
    chk("push+pop full count", 32'(ev_count), 32'd8);
    chk("push+pop full head", 32'(ev_code), 32'h1D);
    chk("push+pop full ovf", 32'(overflow), 32'd1);

    // Drop coinciding with clear keeps the flag.
    in_data = 8'h4B; in_valid = 1'b1; ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("ovf clr vs drop", 32'(overflow), 32'd1);
    chk("ovf clr vs drop count", 32'(ev_count), 32'd8);

    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    $display("ovf_clr: overflow %0b", overflow);
    chk("ovf cleared", 32'(overflow), 32'd0);

    foreach (drain_codes[i]) begin
      chk($sformatf("drain%0d code", i), 32'(ev_code), 32'(drain_codes[i]));
      pop_one();
    end
    chk("drain empty count", 32'(ev_count), 32'd0);
    chk("drain empty valid", 32'(ev_valid), 32'd0);
    pop_one();
    chk("pop on empty", 32'(ev_count), 32'd0);

    // Asynchronous reset between E0 and the next byte.
    send_byte(8'h1C);
    send_byte(8'hE0);
    rst = 1'b0;
    #2;
    $display("async reset: count %0d valid %0b", ev_count, ev_valid);
    chk("async reset count", 32'(ev_count), 32'd0);
    chk("async reset valid", 32'(ev_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_byte(8'h75);
    $display("after reset: byte 75 head %02h ext %0b", ev_code, ev_ext);
    chk("post reset valid", 32'(ev_valid), 32'd1);
    chk("post reset event", word(ev_code, ev_ext, ev_break, ev_mods),
        word(8'h75, 1'b0, 1'b0, 4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
